// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of {inst, pc, ic} entries
// with one-cycle latency, flush for redirects and a synchronous reset.
module if_id_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [31:0]                  in_inst,
    input  logic [31:0]                  in_pc,
    input  logic [1:0]                   in_ic,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [31:0]                  out_inst,
    output logic [31:0]                  out_pc,
    output logic [1:0]                   out_ic,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned IC_W   = 2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [IC_W-1:0]   ic;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    entry_t             head;

    // Handshakes come straight from registered occupancy; no write-through when full.
    always_comb begin
        in_ready  = (count < CNT_W'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Head entry is forced to zero while the queue is empty.
    always_comb begin
        head     = out_valid ? mem[rd_ptr] : '0;
        out_inst = head.inst;
        out_pc   = head.pc;
        out_ic   = head.ic;
    end

    // Pointers and occupancy; flush drops any same-cycle push, pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset only; a flush leaves stale data that is never exposed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && push) begin
            mem[wr_ptr] <= '{inst: in_inst, pc: in_pc, ic: in_ic};
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_inst;
    logic [31:0]   in_pc;
    logic [1:0]    in_ic;
    logic          in_ready;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic [1:0]    out_ic;
    logic [CW-1:0] count;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ic(in_ic),
        .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ic(out_ic), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  ic;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  ic;
        logic        ordy;
        int          exp_count;
        logic        exp_ovalid;
        logic [31:0] exp_pc;
        logic [1:0]  exp_ic;
        logic        exp_irdy;
    } vec_t;

    ent_t model [$];
    vec_t vecs  [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain FIFO of entries, bounded at DEPTH, cleared by reset/flush.
    task automatic model_edge();
        bit do_pop;
        bit do_push;
        do_pop  = (model.size() != 0) && out_ready;
        do_push = in_valid && (model.size() < DEPTH);
        if (reset || flush) begin
            model.delete();
        end else begin
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back('{inst: in_inst, pc: in_pc, ic: in_ic});
        end
    endtask

    task automatic model_check();
        ent_t h;
        h = (model.size() != 0) ? model[0] : '{inst: 32'h0, pc: 32'h0, ic: 2'b00};
        chk("count",     32'(count),     32'(model.size()));
        chk("in_ready",  32'(in_ready),  32'(model.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(model.size() != 0));
        chk("out_inst",  out_inst,       h.inst);
        chk("out_pc",    out_pc,         h.pc);
        chk("out_ic",    32'(out_ic),    32'(h.ic));
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input logic [1:0] ic, input logic ordy);
        reset = rst; flush = fl; in_valid = iv;
        in_inst = inst; in_pc = pc; in_ic = ic; out_ready = ordy;
        #1;
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    function automatic vec_t mkv(input logic rst, input logic fl, input logic iv,
                                 input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [1:0] ic, input logic ordy,
                                 input int ec, input logic eov, input logic [31:0] epc,
                                 input logic [1:0] eic, input logic eir);
        vec_t v;
        v = '{rst: rst, fl: fl, iv: iv, inst: inst, pc: pc, ic: ic, ordy: ordy,
              exp_count: ec, exp_ovalid: eov, exp_pc: epc, exp_ic: eic, exp_irdy: eir};
        return v;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_ic = '0;

        // Directed table: first push, fill to full, ignored 5th push, drain, empty corners.
        vecs.push_back(mkv(1,0,0,32'h0,       32'h0,        2'b00,0, 0,0,32'h0,       2'b00,1));
        vecs.push_back(mkv(0,0,1,32'h24010001,32'hbfc00000, 2'b00,0, 1,1,32'hbfc00000,2'b00,1));
        vecs.push_back(mkv(0,0,1,32'h24020002,32'hbfc00004, 2'b00,0, 2,1,32'hbfc00000,2'b00,1));
        vecs.push_back(mkv(0,0,1,32'h24030003,32'hbfc00008, 2'b00,0, 3,1,32'hbfc00000,2'b00,1));
        vecs.push_back(mkv(0,0,1,32'h24040004,32'hbfc0000c, 2'b00,0, 4,1,32'hbfc00000,2'b00,0));
        vecs.push_back(mkv(0,0,1,32'h24050005,32'hbfc00010, 2'b00,0, 4,1,32'hbfc00000,2'b00,0));
        vecs.push_back(mkv(0,0,1,32'h24050005,32'hbfc00010, 2'b00,1, 3,1,32'hbfc00004,2'b00,1));
        vecs.push_back(mkv(0,0,0,32'h0,       32'h0,        2'b00,1, 2,1,32'hbfc00008,2'b00,1));
        vecs.push_back(mkv(0,0,0,32'h0,       32'h0,        2'b00,1, 1,1,32'hbfc0000c,2'b00,1));
        vecs.push_back(mkv(0,0,0,32'h0,       32'h0,        2'b00,1, 0,0,32'h0,       2'b00,1));
        vecs.push_back(mkv(0,0,1,32'h0,       32'h80000001, 2'b10,1, 1,1,32'h80000001,2'b10,1));
        vecs.push_back(mkv(0,0,1,32'h11111111,32'h80000005, 2'b01,0, 2,1,32'h80000001,2'b10,1));
        vecs.push_back(mkv(0,0,0,32'h0,       32'h0,        2'b00,1, 1,1,32'h80000005,2'b01,1));
        vecs.push_back(mkv(0,0,0,32'h0,       32'h0,        2'b00,1, 0,0,32'h0,       2'b00,1));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].inst, vecs[i].pc,
                 vecs[i].ic, vecs[i].ordy);
            chk($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ovalid));
            chk($sformatf("vec%0d.out_pc", i),    out_pc,         vecs[i].exp_pc);
            chk($sformatf("vec%0d.out_ic", i),    32'(out_ic),    32'(vecs[i].exp_ic));
            chk($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].exp_irdy));
        end

        // Steady push+pop at count=2: pointers wrap, PC sequence stays in order.
        step(1,0,0,32'h0,32'h0,2'b00,0);
        step(0,0,1,32'hA0,32'hbfc00000,2'b00,0);
        step(0,0,1,32'hA1,32'hbfc00004,2'b00,0);
        for (int i = 0; i < 10; i++) begin
            step(0,0,1,32'hA2 + 32'(i),32'hbfc00000 + 32'(4*(i+2)),2'b00,1);
            chk("stream.count", 32'(count), 32'd2);
            chk("stream.pc",    out_pc,     32'hbfc00000 + 32'(4*(i+1)));
        end

        // Flush at count=3 with simultaneous push and pop; pushed entry must vanish.
        step(1,0,0,32'h0,32'h0,2'b00,0);
        for (int i = 0; i < 3; i++) step(0,0,1,32'hC0 + 32'(i),32'h1000 + 32'(4*i),2'b00,0);
        step(0,1,1,32'hDEAD,32'h2000,2'b11,1);
        chk("flush.count",     32'(count),     32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.out_inst",  out_inst,       32'd0);
        step(0,1,1,32'hBEEF,32'h2004,2'b00,0);
        chk("flush2.count",    32'(count),     32'd0);
        step(0,0,1,32'hCAFE,32'h3000,2'b00,0);
        chk("after_flush.pc",  out_pc,         32'h3000);

        // Reset at count=3 together with push and flush.
        step(0,0,1,32'hC3,32'h100c,2'b00,0);
        step(0,0,1,32'hC4,32'h1010,2'b00,0);
        step(1,1,1,32'hFFFF,32'h4000,2'b01,1);
        chk("rst.count",    32'(count),    32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_pc",   out_pc,        32'd0);
        chk("rst.out_ic",   32'(out_ic),   32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
